// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the APB master arbiter.
package apb_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_arb_state_e;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker: first asserted request after index `last`, wrapping.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDXW-1:0]    grant_idx
);
  logic            found;
  logic [IDXW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    // Scan last+1 .. last+NUM_REQ so `last` itself has lowest priority.
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = IDXW'((int'(last) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port among NUM_REQ requesters.
// Optional APB_ARB_PREADY_EN adds a pready input that stretches ACCESS.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
`ifdef APB_ARB_PREADY_EN
  input  logic                      pready,
`endif
  input  logic [DATA_W-1:0]         prdata
);
  localparam int IDXW = $clog2(NUM_REQ);

  apb_arb_state_e      state_q, state_d;
  logic [IDXW-1:0]     last_q, owner_q, gidx;
  logic [NUM_REQ-1:0]  grant, rsp_valid_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q, rsp_rdata_q;
  logic                pwrite_q, pready_w, access_done, grant_en, take;

`ifdef APB_ARB_PREADY_EN
  assign pready_w = pready;
`else
  assign pready_w = 1'b1;
`endif

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_rr (
    .req       (req_valid),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign access_done = (state_q == ACCESS) && pready_w;
  assign grant_en    = !preset && ((state_q == IDLE) || access_done);
  assign take        = grant_en && (|req_valid);
  assign req_ready   = grant_en ? grant : '0;

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = (|req_valid) ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = !access_done ? ACCESS : ((|req_valid) ? SETUP : IDLE);
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      last_q      <= IDXW'(NUM_REQ - 1);
      owner_q     <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        last_q   <= gidx;
        owner_q  <= gidx;
        paddr_q  <= req_addr[gidx*ADDR_W +: ADDR_W];
        pwdata_q <= req_wdata[gidx*DATA_W +: DATA_W];
        pwrite_q <= req_write[gidx];
      end
      // Completion uses the pre-edge pwrite_q, so a same-edge re-grant is harmless.
      rsp_valid_q <= access_done ? (NUM_REQ'(1) << owner_q) : '0;
      if (access_done)
        rsp_rdata_q <= pwrite_q ? '0 : prdata;
    end
  end

  assign psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable   = (state_q == ACCESS);
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with hand-computed expectations.
module tb_apb_master_arbiter;
  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              pclk = 1'b0;
  logic              preset;
  logic [N-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     rsp_rdata, pwdata, prdata;
  logic [AW-1:0]     paddr;
  logic              psel, penable, pwrite;
`ifdef APB_ARB_PREADY_EN
  logic              pready;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
`ifdef APB_ARB_PREADY_EN
    .pready(pready),
`endif
    .prdata(prdata)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    preset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; prdata = '0;
`ifdef APB_ARB_PREADY_EN
    pready = 1'b1;
`endif
    tick(); tick();
    preset = 1'b0; #1;
    nvec++;
    if ({psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata} !== '0) begin
      nerr++;
      $display("FAIL reset_state: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h ready=%b rsp=%b rdata=%h, want all zero",
               psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_single_read();
    req_valid = 4'b0001; req_write = '0; req_addr[0*AW +: AW] = 32'h100; #1;
    nvec++;
    if ({req_ready, psel, penable} !== {4'b0001, 2'b00}) begin
      nerr++; $display("FAIL rd_accept: ready=%b psel=%b penable=%b, want 0001 0 0", req_ready, psel, penable);
    end
    tick(); req_valid = '0; prdata = 32'hDEADBEEF; #1;
    nvec++;
    if ({psel, penable, paddr, pwrite} !== {2'b10, 32'h100, 1'b0}) begin
      nerr++; $display("FAIL rd_setup: psel=%b penable=%b paddr=%h pwrite=%b, want 1 0 100 0", psel, penable, paddr, pwrite);
    end
    tick();
    nvec++;
    if ({psel, penable, rsp_valid} !== {2'b11, 4'b0000}) begin
      nerr++; $display("FAIL rd_access: psel=%b penable=%b rsp=%b, want 1 1 0000", psel, penable, rsp_valid);
    end
    tick(); prdata = 32'h0;
    nvec++;
    if ({rsp_valid, rsp_rdata, psel} !== {4'b0001, 32'hDEADBEEF, 1'b0}) begin
      nerr++; $display("FAIL rd_rsp: rsp=%b rdata=%h psel=%b, want 0001 deadbeef 0", rsp_valid, rsp_rdata, psel);
    end
    tick();
    nvec++;
    if ({rsp_valid, rsp_rdata} !== {4'b0000, 32'hDEADBEEF}) begin
      nerr++; $display("FAIL rd_hold: rsp=%b rdata=%h, want 0000 deadbeef", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_single_write();
    req_valid = 4'b0100; req_write = 4'b0100;
    req_addr[2*AW +: AW] = 32'h20; req_wdata[2*DW +: DW] = 32'hA5A5A5A5; #1;
    nvec++;
    if (req_ready !== 4'b0100) begin
      nerr++; $display("FAIL wr_accept: ready=%b, want 0100", req_ready);
    end
    tick(); req_valid = '0; req_write = '0; #1;
    nvec++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 32'h20, 32'hA5A5A5A5}) begin
      nerr++; $display("FAIL wr_setup: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h", psel, penable, pwrite, paddr, pwdata);
    end
    tick(); prdata = 32'h12345678; #1;
    nvec++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {3'b111, 32'h20, 32'hA5A5A5A5}) begin
      nerr++; $display("FAIL wr_access: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h", psel, penable, pwrite, paddr, pwdata);
    end
    tick(); prdata = '0;
    nvec++;
    if ({rsp_valid, rsp_rdata} !== {4'b0100, 32'h0}) begin
      nerr++; $display("FAIL wr_rsp: rsp=%b rdata=%h, want 0100 00000000", rsp_valid, rsp_rdata);
    end
  endtask

  // All four requesting from reset: grants 0,1,2,3,0 back to back.
  task automatic test_back_to_back();
    logic [3:0] want;
    preset = 1'b1; tick(); preset = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = 32'(i * 16);
      req_wdata[i*DW +: DW] = 32'(i);
    end
    req_valid = 4'b1111; #1;
    nvec++;
    if (req_ready !== 4'b0001) begin
      nerr++; $display("FAIL b2b_first_grant: ready=%b, want 0001", req_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      want = (k == 0) ? 4'b0000 : 4'(1 << ((k - 1) % 4));
      nvec++;
      if ({psel, penable, req_ready, paddr, rsp_valid} !== {2'b10, 4'b0000, 32'((k % 4) * 16), want}) begin
        nerr++; $display("FAIL b2b_setup_%0d: psel=%b penable=%b ready=%b paddr=%h rsp=%b", k, psel, penable, req_ready, paddr, rsp_valid);
      end
      tick();
      if (k == 4) req_valid = '0;
      #1;
      want = (k == 4) ? 4'b0000 : 4'(1 << ((k + 1) % 4));
      nvec++;
      if ({psel, penable, req_ready} !== {2'b11, want}) begin
        nerr++; $display("FAIL b2b_access_%0d: psel=%b penable=%b ready=%b, want 1 1 %b", k, psel, penable, req_ready, want);
      end
    end
    tick();
    nvec++;
    if ({psel, rsp_valid} !== {1'b0, 4'b0001}) begin
      nerr++; $display("FAIL b2b_last_rsp: psel=%b rsp=%b, want 0 0001", psel, rsp_valid);
    end
  endtask

  // last=0 from the previous test; force a grant to 3, then 1 and 3 compete.
  task automatic test_rr_wrap();
    tick();
    req_valid = 4'b1000; #1;
    nvec++;
    if (req_ready !== 4'b1000) begin
      nerr++; $display("FAIL rr_grant3: ready=%b, want 1000", req_ready);
    end
    tick(); req_valid = 4'b1010; #1;
    nvec++;
    if (req_ready !== 4'b0000) begin
      nerr++; $display("FAIL rr_no_grant_setup: ready=%b, want 0000", req_ready);
    end
    tick();
    nvec++;
    if (req_ready !== 4'b0010) begin
      nerr++; $display("FAIL rr_grant1: ready=%b, want 0010", req_ready);
    end
    tick(); req_valid = 4'b1000; #1;
    nvec++;
    if (paddr !== 32'h10) begin
      nerr++; $display("FAIL rr_addr1: paddr=%h, want 00000010", paddr);
    end
    tick();
    nvec++;
    if (req_ready !== 4'b1000) begin
      nerr++; $display("FAIL rr_grant3_again: ready=%b, want 1000", req_ready);
    end
    tick(); req_valid = '0; #1;
    nvec++;
    if (paddr !== 32'h30) begin
      nerr++; $display("FAIL rr_addr3: paddr=%h, want 00000030", paddr);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100; #1;
    nvec++;
    if (req_ready !== 4'b0100) begin
      nerr++; $display("FAIL rst_mid_grant: ready=%b, want 0100", req_ready);
    end
    tick(); req_valid = '0;
    tick(); preset = 1'b1; #1;
    nvec++;
    if ({psel, penable} !== 2'b11) begin
      nerr++; $display("FAIL rst_mid_in_access: psel=%b penable=%b, want 1 1", psel, penable);
    end
    tick(); preset = 1'b0; #1;
    nvec++;
    if ({psel, penable, rsp_valid} !== {2'b00, 4'b0000}) begin
      nerr++; $display("FAIL rst_mid_after: psel=%b penable=%b rsp=%b, want 0 0 0000", psel, penable, rsp_valid);
    end
    tick();
    nvec++;
    if (rsp_valid !== 4'b0000) begin
      nerr++; $display("FAIL rst_mid_no_rsp: rsp=%b, want 0000", rsp_valid);
    end
    req_valid = 4'b1111; #1;
    nvec++;
    if (req_ready !== 4'b0001) begin
      nerr++; $display("FAIL rst_mid_ptr: ready=%b, want 0001", req_ready);
    end
    tick(); req_valid = '0;
    tick(); tick();
    nvec++;
    if (rsp_valid !== 4'b0001) begin
      nerr++; $display("FAIL rst_mid_resume_rsp: rsp=%b, want 0001", rsp_valid);
    end
    tick();
  endtask

`ifdef APB_ARB_PREADY_EN
  task automatic test_pready_wait();
    req_valid = 4'b0001; req_write = '0; req_addr[0*AW +: AW] = 32'h300; #1;
    nvec++;
    if (req_ready !== 4'b0001) begin
      nerr++; $display("FAIL wait_grant: ready=%b, want 0001", req_ready);
    end
    tick(); req_valid = '0; pready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 3) begin pready = 1'b1; prdata = 32'hCAFEF00D; end
      #1;
      nvec++;
      if ({psel, penable, paddr, rsp_valid} !== {2'b11, 32'h300, 4'b0000}) begin
        nerr++; $display("FAIL wait_access_%0d: psel=%b penable=%b paddr=%h rsp=%b", c, psel, penable, paddr, rsp_valid);
      end
    end
    tick();
    nvec++;
    if ({penable, rsp_valid, rsp_rdata} !== {1'b0, 4'b0001, 32'hCAFEF00D}) begin
      nerr++; $display("FAIL wait_rsp: penable=%b rsp=%b rdata=%h, want 0 0001 cafef00d", penable, rsp_valid, rsp_rdata);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_rr_wrap();
    test_reset_mid();
`ifdef APB_ARB_PREADY_EN
    test_pready_wait();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
